// File: rtl/cm_guess_engine_if.sv
// CM byte-bus signals shared between the guess engine and the MCU-facing bus wrapper.
// The engine takes the master view and the wrapper/MCU side takes the slave view.
interface cm_guess_engine_if #(
    parameter int DATA_W = 8
);
    logic              CLK_inter;
    logic [DATA_W-1:0] bus_din;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_oe;

    modport master (
        input  CLK_inter,
        input  bus_din,
        output bus_dout,
        output bus_oe
    );

    modport slave (
        output CLK_inter,
        output bus_din,
        input  bus_dout,
        input  bus_oe
    );
endinterface

// File: rtl/cm_guess_engine.sv
// Brute-force guess engine: sends framed odometer guesses on MCU strobe falls,
// then waits for a YES/NO reply with timeout, bounded retransmission and exhaustion detection.
module cm_guess_engine #(
    parameter int                DATA_W        = 8,
    parameter int                GUESS_BYTES   = 2,
    parameter logic [DATA_W-1:0] RANGE_MIN     = 8'h06,
    parameter logic [DATA_W-1:0] RANGE_MAX     = 8'hFF,
    parameter int                REPLY_TIMEOUT = 50000,
    parameter int                MAX_RETRIES   = 3,
    parameter int                SYNC_STAGES   = 2
) (
    input  logic                            CLK_50,
    input  logic                            RST_N,
    cm_guess_engine_if.master               bus,
    output logic [GUESS_BYTES*DATA_W-1:0]   guess_value,
    output logic                            busy,
    output logic                            found,
    output logic                            exhausted,
    output logic                            error,
    output logic [31:0]                     attempt_cnt
);

    localparam int IDX_W   = (GUESS_BYTES > 1) ? $clog2(GUESS_BYTES) : 1;
    localparam int TMO_W   = (REPLY_TIMEOUT > 0) ? $clog2(REPLY_TIMEOUT + 1) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [DATA_W-1:0] START_B = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] BEGIN_B = DATA_W'(8'h02);
    localparam logic [DATA_W-1:0] YES_B   = DATA_W'(8'h03);
    localparam logic [DATA_W-1:0] NO_B    = DATA_W'(8'h04);
    localparam logic [DATA_W-1:0] END_B   = DATA_W'(8'h05);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(GUESS_BYTES - 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD    = TMO_W'(REPLY_TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        SEND_START,
        SEND_DATA,
        SEND_END,
        SETTLE,
        WAIT_REPLY
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]    guess_q [GUESS_BYTES];
    logic [DATA_W-1:0]    guess_d [GUESS_BYTES];
    logic [DATA_W-1:0]    guessInc [GUESS_BYTES];
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [31:0]          attempt_q, attempt_d;
    logic                 found_q, found_d;
    logic                 exhausted_q, exhausted_d;
    logic                 error_q, error_d;
    logic                 oe_q, oe_d;
    logic [DATA_W-1:0]    dout_q, dout_d;

    logic [SYNC_STAGES-1:0] clkSync_q;
    logic [DATA_W-1:0]      busSync_q [SYNC_STAGES];
    logic                   clkPrev_q;
    logic                   strobeFall;
    logic [DATA_W-1:0]      busRx;
    logic                   allMax;
    logic                   incCarry;

    // Both the strobe and the raw bus byte cross from the MCU domain here.
    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            clkSync_q <= '0;
            clkPrev_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                busSync_q[i] <= '0;
            end
        end else begin
            clkSync_q    <= {clkSync_q[SYNC_STAGES-2:0], bus.CLK_inter};
            clkPrev_q    <= clkSync_q[SYNC_STAGES-1];
            busSync_q[0] <= bus.bus_din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                busSync_q[i] <= busSync_q[i-1];
            end
        end
    end

    assign strobeFall = clkPrev_q & ~clkSync_q[SYNC_STAGES-1];
    assign busRx      = busSync_q[SYNC_STAGES-1];

    always_comb begin
        incCarry = 1'b1;
        allMax   = 1'b1;
        for (int i = 0; i < GUESS_BYTES; i++) begin
            guessInc[i] = guess_q[i];
            if (guess_q[i] != RANGE_MAX) begin
                allMax = 1'b0;
            end
            if (incCarry) begin
                if (guess_q[i] == RANGE_MAX) begin
                    guessInc[i] = RANGE_MIN;
                end else begin
                    guessInc[i] = guess_q[i] + 1'b1;
                    incCarry    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            attempt_q   <= '0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            error_q     <= 1'b0;
            oe_q        <= 1'b0;
            dout_q      <= '0;
            for (int i = 0; i < GUESS_BYTES; i++) begin
                guess_q[i] <= RANGE_MIN;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            attempt_q   <= attempt_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            error_q     <= error_d;
            oe_q        <= oe_d;
            dout_q      <= dout_d;
            for (int i = 0; i < GUESS_BYTES; i++) begin
                guess_q[i] <= guess_d[i];
            end
        end
    end

    // A reply is only honoured in WAIT_REPLY, and a real reply beats a same-cycle timeout.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        attempt_d   = attempt_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        error_d     = error_q;
        for (int i = 0; i < GUESS_BYTES; i++) begin
            guess_d[i] = guess_q[i];
        end

        case (state_q)
            IDLE: begin
                if (busRx == BEGIN_B) begin
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    error_d     = 1'b0;
                    attempt_d   = '0;
                    retry_d     = '0;
                    for (int i = 0; i < GUESS_BYTES; i++) begin
                        guess_d[i] = RANGE_MIN;
                    end
                    state_d = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (strobeFall) begin
                    state_d = SEND_START;
                end
            end
            SEND_START: begin
                if (strobeFall) begin
                    idx_d   = '0;
                    state_d = SEND_DATA;
                end
            end
            SEND_DATA: begin
                if (strobeFall) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SEND_END;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            SEND_END: begin
                if (strobeFall) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                tmo_d   = TMO_LOAD;
                state_d = WAIT_REPLY;
            end
            WAIT_REPLY: begin
                if (busRx == YES_B) begin
                    found_d = 1'b1;
                    state_d = IDLE;
                end else if (busRx == NO_B) begin
                    if (attempt_q != 32'hFFFF_FFFF) begin
                        attempt_d = attempt_q + 32'd1;
                    end
                    retry_d = '0;
                    if (allMax) begin
                        exhausted_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        for (int i = 0; i < GUESS_BYTES; i++) begin
                            guess_d[i] = guessInc[i];
                        end
                        state_d = WAIT_SLOT;
                    end
                end else if (tmo_q == '0) begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = WAIT_SLOT;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus drive is decoded from the current state and registered, so it lags the state by a cycle.
    always_comb begin
        oe_d   = 1'b0;
        dout_d = '0;
        case (state_q)
            SEND_START: begin
                oe_d   = 1'b1;
                dout_d = START_B;
            end
            SEND_DATA: begin
                oe_d   = 1'b1;
                dout_d = guess_q[idx_q];
            end
            SEND_END: begin
                oe_d   = 1'b1;
                dout_d = END_B;
            end
            default: begin
                oe_d   = 1'b0;
                dout_d = '0;
            end
        endcase
    end

    for (genvar g = 0; g < GUESS_BYTES; g++) begin : g_guessOut
        assign guess_value[g*DATA_W +: DATA_W] = guess_q[g];
    end

    assign bus.bus_oe   = oe_q;
    assign bus.bus_dout = dout_q;
    assign busy         = (state_q != IDLE);
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign error        = error_q;
    assign attempt_cnt  = attempt_q;

endmodule

// File: tb/tb_cm_guess_engine.sv
// Bench for cm_guess_engine: an MCU model drives frames and replies while a transaction-level
// model of the guess search predicts status outputs, checked every cycle they are stable.
module tb_cm_guess_engine;

    localparam int         DATA_W = 8;
    localparam int         GB     = 2;
    localparam logic [7:0] RMIN   = 8'h06;
    localparam logic [7:0] RMAX   = 8'h09;
    localparam int         TMO    = 20;
    localparam int         MR     = 3;
    localparam int         BASE   = RMAX - RMIN + 1;

    localparam int REPLY_SILENT = 0;
    localparam int REPLY_NO     = 1;
    localparam int REPLY_YES    = 2;

    logic              CLK_50 = 1'b0;
    logic              RST_N  = 1'b0;
    logic [7:0]        mcuDrive = 8'h00;
    logic [GB*8-1:0]   guess_value;
    logic              busy, found, exhausted, error;
    logic [31:0]       attempt_cnt;

    cm_guess_engine_if #(.DATA_W(DATA_W)) busIf ();

    // The bus reads back the engine's own byte whenever it drives, otherwise the MCU's byte.
    assign busIf.bus_din = busIf.bus_oe ? busIf.bus_dout : mcuDrive;

    cm_guess_engine #(
        .DATA_W(DATA_W), .GUESS_BYTES(GB), .RANGE_MIN(RMIN), .RANGE_MAX(RMAX),
        .REPLY_TIMEOUT(TMO), .MAX_RETRIES(MR), .SYNC_STAGES(2)
    ) dut (
        .CLK_50(CLK_50), .RST_N(RST_N), .bus(busIf),
        .guess_value(guess_value), .busy(busy), .found(found),
        .exhausted(exhausted), .error(error), .attempt_cnt(attempt_cnt)
    );

    always #5 CLK_50 = ~CLK_50;

    int         checks = 0;
    int         errors = 0;
    bit         modelValid = 1'b0;
    logic [7:0] mGuess [GB];
    int         mAttempt;
    int         mRetry;
    bit         mFound, mExh, mErr, mBusy;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [GB*8-1:0] packGuess();
        logic [GB*8-1:0] r;
        for (int i = 0; i < GB; i++) r[i*8 +: 8] = mGuess[i];
        return r;
    endfunction

    // The guess is a GB-digit number in base BASE offset by RMIN, byte 0 least significant.
    function automatic int guessIndex();
        int v = 0;
        for (int i = GB - 1; i >= 0; i--) v = v * BASE + (int'(mGuess[i]) - int'(RMIN));
        return v;
    endfunction

    function automatic int lastIndex();
        int v = 1;
        for (int i = 0; i < GB; i++) v = v * BASE;
        return v - 1;
    endfunction

    task automatic setGuessIndex(input int v);
        int t = v;
        for (int i = 0; i < GB; i++) begin
            mGuess[i] = RMIN + 8'(t % BASE);
            t = t / BASE;
        end
    endtask

    task automatic modelReset();
        setGuessIndex(0);
        mAttempt = 0; mRetry = 0;
        mFound = 0; mExh = 0; mErr = 0; mBusy = 0;
    endtask

    always @(negedge CLK_50) begin
        if (modelValid) begin
            checkOutput("busy", busy, mBusy);
            checkOutput("found", found, mFound);
            checkOutput("exhausted", exhausted, mExh);
            checkOutput("error", error, mErr);
            checkOutput("attempt_cnt", attempt_cnt, 32'(mAttempt));
            checkOutput("guess_value", guess_value, packGuess());
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK_50);
        #1;
    endtask

    task automatic pulse();
        busIf.CLK_inter = 1'b0;
        waitCycles(10);
        busIf.CLK_inter = 1'b1;
        waitCycles(10);
    endtask

    task automatic startRun();
        modelValid = 1'b0;
        mcuDrive = 8'h02;
        waitCycles(6);
        mcuDrive = 8'h00;
        waitCycles(2);
        if (!mBusy) begin
            modelReset();
            mBusy = 1;
        end
        modelValid = 1'b1;
    endtask

    // One full frame from the MCU side (slot pulse, START, data, END) followed by a reply or silence.
    task automatic applyStimulus(input int reply);
        bit         active = mBusy;
        logic [7:0] expByte;
        for (int k = 0; k <= GB + 1; k++) begin
            pulse();
            if (k == 0) expByte = 8'h01;
            else if (k <= GB) expByte = mGuess[k-1];
            else expByte = 8'h05;
            checkOutput("frameOe", busIf.bus_oe, active);
            checkOutput("frameDout", busIf.bus_dout, active ? expByte : 8'h00);
        end
        modelValid = 1'b0;
        busIf.CLK_inter = 1'b0;
        waitCycles(2);
        mcuDrive = (reply == REPLY_NO) ? 8'h04 : (reply == REPLY_YES) ? 8'h03 : 8'h00;
        waitCycles(8);
        busIf.CLK_inter = 1'b1;
        waitCycles(6);
        mcuDrive = 8'h00;
        checkOutput("endOe", busIf.bus_oe, 1'b0);
        checkOutput("endDout", busIf.bus_dout, 8'h00);
        waitCycles(reply == REPLY_SILENT ? TMO + 20 : 4);
        if (active) begin
            case (reply)
                REPLY_YES: begin
                    mFound = 1; mBusy = 0;
                end
                REPLY_NO: begin
                    mAttempt++;
                    mRetry = 0;
                    if (guessIndex() == lastIndex()) begin
                        mExh = 1; mBusy = 0;
                    end else begin
                        setGuessIndex(guessIndex() + 1);
                    end
                end
                default: begin
                    if (mRetry < MR) mRetry++;
                    else begin
                        mErr = 1; mBusy = 0;
                    end
                end
            endcase
        end
        // Leave a stale byte on the bus that the engine must ignore in its current state.
        case ($urandom_range(0, 4))
            0: mcuDrive = 8'h03;
            1: mcuDrive = 8'h04;
            2: mcuDrive = mBusy ? 8'h02 : 8'h00;
            3: mcuDrive = 8'hAA;
            default: mcuDrive = 8'h00;
        endcase
        modelValid = 1'b1;
    endtask

    initial begin
        #3ms;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int guard;
        int r;
        busIf.CLK_inter = 1'b1;
        RST_N = 1'b0;
        modelReset();
        waitCycles(3);
        checkOutput("rstOe", busIf.bus_oe, 1'b0);
        checkOutput("rstDout", busIf.bus_dout, 8'h00);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstGuess", guess_value, 16'h0606);
        checkOutput("rstAttempt", attempt_cnt, 32'd0);
        RST_N = 1'b1;
        waitCycles(3);
        modelValid = 1'b1;

        startRun();
        applyStimulus(REPLY_NO);
        checkOutput("litGuessAfterNo", guess_value, 16'h0607);
        checkOutput("litAttempt1", attempt_cnt, 32'd1);
        applyStimulus(REPLY_NO);
        applyStimulus(REPLY_NO);
        checkOutput("litGuessTop", guess_value, 16'h0609);
        applyStimulus(REPLY_NO);
        checkOutput("litGuessCarry", guess_value, 16'h0706);

        guard = 0;
        while (mBusy && guard < 40) begin
            applyStimulus(REPLY_NO);
            guard++;
        end
        checkOutput("litExhausted", exhausted, 1'b1);
        checkOutput("litExhBusy", busy, 1'b0);
        checkOutput("litExhAttempt", attempt_cnt, 32'd16);
        checkOutput("litExhGuess", guess_value, 16'h0909);

        startRun();
        checkOutput("litRestartExh", exhausted, 1'b0);
        checkOutput("litRestartGuess", guess_value, 16'h0606);
        checkOutput("litRestartAttempt", attempt_cnt, 32'd0);

        applyStimulus(REPLY_SILENT);
        applyStimulus(REPLY_SILENT);
        checkOutput("litRetryBusy", busy, 1'b1);
        applyStimulus(REPLY_NO);
        checkOutput("litRetryResume", guess_value, 16'h0607);
        for (int i = 0; i < MR; i++) applyStimulus(REPLY_SILENT);
        checkOutput("litRetryNoErr", error, 1'b0);
        applyStimulus(REPLY_SILENT);
        checkOutput("litError", error, 1'b1);
        checkOutput("litErrorBusy", busy, 1'b0);

        startRun();
        applyStimulus(REPLY_YES);
        checkOutput("litFound", found, 1'b1);
        checkOutput("litFoundGuess", guess_value, 16'h0606);

        for (int n = 0; n < 40; n++) begin
            if (!mBusy) begin
                if ($urandom_range(0, 9) < 7) startRun();
                else applyStimulus(int'($urandom_range(0, 2)));
            end else begin
                r = int'($urandom_range(0, 9));
                applyStimulus(r < 7 ? REPLY_NO : (r < 8 ? REPLY_YES : REPLY_SILENT));
            end
        end

        startRun();
        pulse();
        pulse();
        checkOutput("midFrameOe", busIf.bus_oe, 1'b1);
        modelValid = 1'b0;
        @(negedge CLK_50);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("asyncOeDrop", busIf.bus_oe, 1'b0);
        checkOutput("asyncDoutDrop", busIf.bus_dout, 8'h00);
        modelReset();
        modelValid = 1'b1;
        waitCycles(3);
        RST_N = 1'b1;
        waitCycles(5);
        checkOutput("postRstGuess", guess_value, 16'h0606);
        checkOutput("postRstBusy", busy, 1'b0);

        modelValid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cm_guess_engine.md
Name: cm_guess_engine

Overview:
- Parametrised next-generation brute-force guess engine on the MCU↔FPGA CM byte bus.
- Sends framed multi-byte guesses (START, N data bytes, END), one byte per falling edge of the MCU-driven CLK_inter.
- Waits for a YES/NO reply and advances an odometer-style guess only on NO.
- Adds reply timeout with bounded retransmission, range exhaustion detection, and status/attempt outputs.
- Sits between the top level and cm_bus_if; the tri-state bus stays in cm_bus_if.

Parameters:
- DATA_W, 8, bus byte width.
- GUESS_BYTES, 2, data bytes per guess frame (≥1).
- RANGE_MIN, 8'h06, per-byte lowest guess value.
- RANGE_MAX, 8'hFF, per-byte highest guess value (≥ RANGE_MIN).
- REPLY_TIMEOUT, 50000, CLK_50 cycles to wait for a reply before retransmitting.
- MAX_RETRIES, 3, number of retransmissions of one guess before error.
- SYNC_STAGES, 2, synchroniser depth for CLK_inter and bus input (≥2).

Ports:
- CLK_50  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CLK_inter  in  1  MCU strobe, asynchronous.
- bus_din  in  DATA_W  raw bus value from cm_bus_if.
- bus_dout  out  DATA_W  byte to drive.
- bus_oe  out  1  drive enable to cm_bus_if.
- guess_value  out  GUESS_BYTES*DATA_W  current guess; byte 0 = [DATA_W-1:0].
- busy  out  1  high in any state except IDLE.
- found  out  1  sticky; last run ended on YES.
- exhausted  out  1  sticky; range fully searched without YES.
- error  out  1  sticky; retry limit hit.
- attempt_cnt  out  32  count of NO replies in the current run, saturating.

Behaviour:
- Reset (async, RST_N=0):
  - State IDLE.
  - bus_oe=0, bus_dout=0.
  - Every guess byte = RANGE_MIN.
  - found, exhausted, error = 0; attempt_cnt=0; retry count=0.
- Synchronisation:
  - CLK_inter and bus_din each pass through SYNC_STAGES flops.
  - A fall event is the last stage at 0 while the previous-sample register holds 1; it lasts exactly one cycle.
  - All protocol compares use the last synchronised bus stage.
- Protocol bytes:
  - BEGIN = 8'h02, YES = 8'h03, NO = 8'h04 (received).
  - START = 8'h01, END = 8'h05 (sent).
- States and transitions:
  - IDLE: bus = BEGIN → clear found/exhausted/error/attempt_cnt, load all guess bytes with RANGE_MIN, go to WAIT_SLOT.
  - WAIT_SLOT: fall → SEND_START.
  - SEND_START: oe=1, dout=START. Fall → SEND_DATA with byte index 0.
  - SEND_DATA: oe=1, dout = guess byte[index].
    - Fall with index < GUESS_BYTES-1 → index+1, stay.
    - Fall at the last index → SEND_END.
  - SEND_END: oe=1, dout=END. Fall → SETTLE.
  - SETTLE: one cycle; oe=0; load timeout counter = REPLY_TIMEOUT. Always → WAIT_REPLY.
  - WAIT_REPLY: oe=0; timeout counter decrements each cycle.
    - bus=YES: found=1 → IDLE; guess held.
    - bus=NO: attempt_cnt+1 (saturating); retry count=0.
      - If every byte == RANGE_MAX: exhausted=1 → IDLE.
      - Otherwise increment the odometer → WAIT_SLOT.
    - Counter reaches 0 with no reply: if retry count < MAX_RETRIES, retry count+1 → WAIT_SLOT with the same guess; otherwise error=1 → IDLE.
    - YES/NO take priority over a timeout in the same cycle.
- Odometer increment:
  - Byte 0 increments.
  - A byte at RANGE_MAX wraps to RANGE_MIN and carries into the next byte.
  - Completes in one cycle.
- Outputs: bus_oe and bus_dout are registered Moore outputs and change the cycle after the state change. bus_dout=0 whenever oe=0.
- Ignored inputs:
  - Stale YES/NO in any state other than WAIT_REPLY is ignored.
  - BEGIN in any state other than IDLE is ignored.
- Reset mid-frame: bus_oe drops asynchronously and immediately.
- Default state decode → IDLE.

Test Plan:
- Reset, bus=02, 4 CLK_inter pulses (GUESS_BYTES=2) → bus shows 01,06,06,05 on successive pulses; oe=0 after the END fall; busy=1.
- Reply NO after the first frame → next frame data 07,06; attempt_cnt=1.
- Preload byte0=FF via NO sequence; reply NO → next data 06,07 (wrap and carry).
- Guess FF,FF and reply NO → exhausted=1, busy=0, IDLE; next bus=02 clears exhausted and restarts at 06,06.
- No reply, REPLY_TIMEOUT=20, MAX_RETRIES=3 → identical frame retransmitted 3 times; on the 4th timeout error=1, IDLE. A reply NO on retry 2 resumes increment and resets the retry count.
- RST_N low during SEND_DATA → bus_oe=0 the same cycle; all status outputs 0; guess 06,06 after release.
